mem_ctrl: RTL and testbench

//  Memory bus controller directly downstream of the CPU's mem_rd/mem_wr strobes, the MAR address and the MDR write data.

---
 rtl/mem_ctrl_pkg.sv | 21 ++
 rtl/mem_ctrl_wait_timer.sv | 42 ++++
 rtl/mem_ctrl.sv | 138 +++++++++++++
 tb/tb_mem_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_ctrl_pkg : shared state and operation types for the memory controller
// Revision     : 1.0
// ----------------------------------------------------------------------------
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    HOLD   = 2'd3
  } mem_state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } mem_op_t;

endpackage
`default_nettype wire

// File: rtl/mem_ctrl_wait_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wait_timer : saturating wait-cycle counter, hit asserted while count == LIMIT
// Revision   : 1.0
// ----------------------------------------------------------------------------
module wait_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam int         W   = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != LIM)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign hit = (count_q == LIM);

endmodule
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_ctrl : turns CPU mem_rd/mem_wr levels into one handshaked RAM access
//            with a watchdog that aborts unacknowledged accesses as bus errors
// Revision : 1.0
// ----------------------------------------------------------------------------
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_rd,
  input  logic                  mem_wr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  done,
  output logic                  bus_err,
  output logic                  busy,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  input  logic                  ram_ack
);

  mem_state_t            state_q, state_d;
  mem_op_t               op_q, op_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic start;
  logic timer_clr;
  logic timer_hit;

  // The timer also counts the launching edge, so it reads k in the k-th ACCESS cycle.
  assign start     = (state_q == IDLE) && (mem_rd ^ mem_wr);
  assign timer_clr = !(start || (state_q == ACCESS));

  wait_timer #(
    .LIMIT (TIMEOUT)
  ) u_wait_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (timer_clr),
    .en    (!timer_clr),
    .hit   (timer_hit)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ram_en  = 1'b0;
    ram_we  = 1'b0;
    done    = 1'b0;
    bus_err = 1'b0;
    busy    = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_rd && mem_wr) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end else if (mem_rd || mem_wr) begin
          op_d    = mem_wr ? OP_WR : OP_RD;
          addr_d  = addr;
          wdata_d = wdata;
          err_d   = 1'b0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        ram_en = 1'b1;
        ram_we = (op_q == OP_WR);
        busy   = 1'b1;
        // An ack in the watchdog's final cycle still completes normally.
        if (ram_ack) begin
          if (op_q == OP_RD) begin
            rdata_d = ram_rdata;
          end
          state_d = RESP;
        end else if (timer_hit) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end
      end
      RESP: begin
        done    = 1'b1;
        bus_err = err_q;
        busy    = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (!mem_rd && !mem_wr) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_RD;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata     = rdata_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_ctrl : randomized transaction-level bench for mem_ctrl
// Revision    : 1.0
// ----------------------------------------------------------------------------
module tb_mem_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_rd = 1'b0;
  logic          mem_wr = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          done;
  logic          bus_err;
  logic          busy;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic          ram_ack = 1'b0;

  int            n_checks = 0;
  int            n_fail = 0;
  logic [DW-1:0] model_rdata = '0;

  always #5 clk = ~clk;

  mem_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .done      (done),
    .bus_err   (bus_err),
    .busy      (busy),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .ram_ack   (ram_ack)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // kind: 0 read, 1 write, 2 both strobes. lat: ACCESS cycle carrying the ack, 0 = never.
  task automatic run_txn(input int kind, input int lat, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd_val, input int hold);
    logic          is_wr;
    logic          exp_err;
    int            exp_en;
    int            en_n;
    logic [31:0]   exp_rdata;
    logic          got_done;

    is_wr     = (kind == 1);
    exp_en    = (kind == 2) ? 0 : ((lat >= 1 && lat <= TO) ? lat : TO);
    exp_err   = (kind == 2) || (lat < 1) || (lat > TO);
    exp_rdata = exp_err ? 32'h0 : ((kind == 0) ? rd_val : model_rdata);

    @(negedge clk);
    mem_rd  = (kind != 1);
    mem_wr  = (kind != 0);
    addr    = a;
    wdata   = wd;
    ram_ack = 1'b0;
    en_n     = 0;
    got_done = 1'b0;

    for (int cyc = 1; cyc <= 40 && !got_done; cyc++) begin
      @(negedge clk);
      if (ram_en) begin
        en_n++;
        chk("ram_we", ram_we, is_wr);
        chk("ram_addr", ram_addr, a);
        chk("ram_wdata", ram_wdata, wd);
        chk("busy_access", busy, 1);
        chk("done_early", done, 0);
        addr      = $urandom;
        wdata     = $urandom;
        ram_ack   = (en_n == lat);
        ram_rdata = (en_n == lat) ? rd_val : $urandom;
      end else if (done) begin
        got_done = 1'b1;
        chk("en_cycles", en_n, exp_en);
        chk("done_latency", cyc, exp_en + 1);
        chk("bus_err", bus_err, exp_err);
        chk("rdata", rdata, exp_rdata);
        chk("busy_resp", busy, 1);
        ram_ack   = 1'($urandom % 2);
        ram_rdata = $urandom;
      end
    end
    chk("done_seen", got_done, 1);
    if (got_done) model_rdata = exp_rdata;

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_done", done, 0);
      chk("hold_ram_en", ram_en, 0);
      chk("hold_busy", busy, 0);
      chk("hold_rdata", rdata, model_rdata);
      ram_ack   = 1'($urandom % 2);
      ram_rdata = $urandom;
    end
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    ram_ack = 1'b0;
    @(negedge clk);
    chk("release_busy", busy, 0);
    chk("release_ram_en", ram_en, 0);
  endtask

  initial begin
    int k;
    repeat (3) @(negedge clk);
    chk("rst_rdata", rdata, 0);
    chk("rst_done", done, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    rst_n = 1'b1;

    run_txn(0, 1, $urandom, $urandom, 32'hDEADBEEF, 0);
    run_txn(1, 5, 32'h10, 32'hA5A5A5A5, $urandom, 1);
    run_txn(0, 1, $urandom, $urandom, $urandom, 20);
    run_txn(0, 0, $urandom, $urandom, $urandom, 3);
    run_txn(0, TO, $urandom, $urandom, $urandom, 1);
    run_txn(1, TO + 1, $urandom, $urandom, $urandom, 2);
    run_txn(2, 1, $urandom, $urandom, $urandom, 2);

    // Asynchronous reset in the middle of an access.
    @(negedge clk);
    mem_rd = 1'b1;
    addr   = 32'h0000_0040;
    @(negedge clk);
    chk("pre_rst_ram_en", ram_en, 1);
    #2 rst_n = 1'b0;
    mem_rd = 1'b0;
    #1;
    chk("arst_ram_en", ram_en, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_ram_addr", ram_addr, 0);
    chk("arst_rdata", rdata, 0);
    model_rdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_done", done, 0);
      chk("post_rst_ram_en", ram_en, 0);
    end
    run_txn(0, 2, $urandom, $urandom, 32'h1234_5678, 0);

    for (int i = 0; i < 40; i++) begin
      k = ($urandom % 8 == 0) ? 2 : int'($urandom % 2);
      run_txn(k, int'($urandom_range(0, TO + 2)), $urandom, $urandom, $urandom,
              int'($urandom_range(0, 4)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
